regfile_wport_arbiter: RTL and testbench
========================================

# regfile_wport_arbiter

Shares the register file's single write port between the core writeback path and an IO/debug requester, which loads switch and button values into registers. The core has fixed priority. IO writes are buffered in a small FIFO and drain in cycles where the core is not writing. A starvation counter forces a one-cycle core stall so that IO writes always make progress. The block sits between writeback/IO and the register file's write inputs (write enable, destination register, write data).

## Interface
- FIFO_DEPTH, 4: IO write buffer entries; power of two, at least 2.
- STARVE_LIMIT, 8: consecutive core-won cycles with a non-empty FIFO before a forced IO slot; at least 1.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_we  in  1  core writeback request.
- core_waddr  in  5  core destination register.
- core_wdata  in  32  core write data.
- io_valid  in  1  IO write request.
- io_addr  in  5  IO destination register.
- io_data  in  32  IO write data.
- io_ready  out  1  FIFO can accept; transfer occurs when io_valid and io_ready are both high.
- rf_we  out  1  registered write enable to the register file.
- rf_waddr  out  5  registered write address.
- rf_wdata  out  32  registered write data.
- core_stall  out  1  core must hold its current instruction and writeback this cycle.
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Core request is effective when core_we=1, core_waddr≠0, and state=NORMAL.
- FIFO head is valid when fifo_count>0.
- Source selection, evaluated every cycle:
  - NORMAL with an effective core request: the core wins.
  - Otherwise, if the head is valid: the head wins and is popped.
  - Otherwise: no write.
- Winner's address and data are registered into rf_waddr/rf_wdata, with rf_we=1. With no winner, rf_we=0 and rf_waddr/rf_wdata hold their previous values.
- Writes to x0:
  - Core writes to x0 never reach the port.
  - IO transfers with io_addr=0 complete the handshake but are discarded, not pushed.
- io_ready = (fifo_count < FIFO_DEPTH). There is no bypass: when full, io_ready=0 even in a cycle that pops.
- Push and pop in the same cycle leave fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- No address coalescing:
  - IO entries commit in push order.
  - A later IO commit overwrites any earlier core write to the same register.
- starve_cnt, width ≥ log2(STARVE_LIMIT)+1:
  - Increments on each edge where the FIFO is non-empty and the core wins.
  - Clears on any pop, and whenever the FIFO is empty.
- FSM has two states:
  - NORMAL: core_stall=0. Moves to FORCE on the edge where starve_cnt would reach STARVE_LIMIT; starve_cnt clears on that edge.
  - FORCE: core_stall=1 (a Moore output). core_we is ignored and the FIFO head pops. Always returns to NORMAL after one cycle.
- The stalled core re-presents the same write the next cycle, so no core write is lost.
- Reset asserted mid-operation:
  - FIFO is flushed and pending IO writes are lost.
  - A write in flight on rf_* is dropped.
  - FSM returns to NORMAL.

## Timing
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - core_stall=0, fifo_count=0, io_ready=1.
  - state=NORMAL, starve_cnt=0.
- Core latency: core_we sampled at edge N gives rf_we=1 in the cycle after edge N (1 cycle).
- IO latency: a push at edge N, with no core contention, pops at edge N+1; rf_we=1 after edge N+1 (2 cycles).
- The register file writes on the edge following rf_we=1.
- Worst-case IO wait behind continuous core writes: STARVE_LIMIT core wins, then 1 forced cycle.

## Test plan
- Reset value check: hold reset=0 mid-stream with 3 IO entries queued -> all outputs at reset values, fifo_count=0, io_ready=1 immediately (asynchronous); no rf_we pulse after release.
- Core latency: core_we=1, addr 5, data 0x1234 for one cycle -> one cycle later rf_we=1, rf_waddr=5, rf_wdata=0x1234; core_waddr=0 -> rf_we stays 0.
- IO drain: push IO (addr 22, data 1) with core idle -> rf_we=1, addr 22, two edges after the push; fifo_count returns to 0.
- Full FIFO: push 4 entries while the core writes continuously, then a fifth push -> io_ready=0 and the fifth entry is not accepted; with io_valid held, it is accepted once a pop frees a slot.
- Starvation: core writes every cycle with 1 IO entry queued -> exactly 8 core commits, then core_stall=1 for one cycle in which the IO entry commits, then the core resumes and its held write commits.
- Ordering: push IO writes (7,0xA) then (7,0xB), and core writes (7,0xC) before they drain -> commit order is C, A, B; the final register value is 0xB.

Source files
------------

// File: rtl/regfile_wport_arbiter_if.sv
// rtl/regfile_wport_arbiter_if.sv - bus bundle between writeback/IO and the register file write port
//
// Groups the core writeback request, the IO/debug write handshake and the
// registered register-file write outputs.
//   master : environment side (core writeback, IO requester, register file)
//   slave  : arbiter side
interface regfile_wport_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          core_we;
  logic [4:0]    core_waddr;
  logic [31:0]   core_wdata;
  logic          io_valid;
  logic [4:0]    io_addr;
  logic [31:0]   io_data;
  logic          io_ready;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          core_stall;
  logic [CW-1:0] fifo_count;

  modport master (
    output core_we, core_waddr, core_wdata,
    output io_valid, io_addr, io_data,
    input  io_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  core_stall, fifo_count
  );

  modport slave (
    input  core_we, core_waddr, core_wdata,
    input  io_valid, io_addr, io_data,
    output io_ready,
    output rf_we, rf_waddr, rf_wdata,
    output core_stall, fifo_count
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// rtl/regfile_wport_arbiter.sv - register file write-port arbiter, core priority with buffered IO writes
//
// regfile_wport_fifo : small circular buffer for pending IO writes.
//   clk, reset(active-low async), push/push_data, pop/head_data, count, full, empty.
// regfile_wport_arbiter : top.
//   clk, reset(active-low async), bus (slave modport of regfile_wport_arbiter_if).
//   Core writes win whenever effective; IO writes drain from the FIFO otherwise.
//   A starvation counter forces a one-cycle core stall so queued IO writes progress.

module regfile_wport_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  // Pointers are exactly log2(DEPTH) bits, so incrementing wraps modulo DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: a flush only has to clear the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign count     = cnt;
  assign full      = (cnt == DEPTH_C);
  assign empty     = (cnt == '0);
endmodule

module regfile_wport_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_wport_arbiter_if.slave  bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_nxt;

  logic          core_eff;
  logic          head_valid;
  logic          pop;
  logic          push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [36:0]   head_data;
  logic [CW-1:0] fifo_cnt;

  logic          rf_we_q;
  logic [4:0]    rf_waddr_q;
  logic [31:0]   rf_wdata_q;

  // Core writes to x0 are dropped here, and core_we is ignored while stalled.
  assign core_eff   = bus.core_we && (bus.core_waddr != 5'd0) && (state == ST_NORMAL);
  assign head_valid = !fifo_empty;
  assign pop        = !core_eff && head_valid;

  // No bypass: a full FIFO refuses even when it pops this cycle. IO writes to
  // x0 still complete the handshake but are never stored.
  assign bus.io_ready = !fifo_full;
  assign push         = bus.io_valid && !fifo_full && (bus.io_addr != 5'd0);

  regfile_wport_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (37)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({bus.io_addr, bus.io_data}),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Starvation only accrues while something waits and the core keeps winning.
  // The edge that would reach STARVE_LIMIT instead enters FORCE, which pops.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      ST_NORMAL: begin
        if (!head_valid || pop) begin
          starve_nxt = '0;
        end else if (core_eff) begin
          if (starve_cnt == STARVE_LAST) begin
            starve_nxt = '0;
            state_nxt  = ST_FORCE;
          end else begin
            starve_nxt = starve_cnt + 1'b1;
          end
        end
      end
      ST_FORCE: begin
        starve_nxt = '0;
        state_nxt  = ST_NORMAL;
      end
      default: begin
        starve_nxt = '0;
        state_nxt  = ST_NORMAL;
      end
    endcase
  end

  // Address/data hold their last value when no one writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      rf_we_q <= core_eff || pop;
      if (core_eff) begin
        rf_waddr_q <= bus.core_waddr;
        rf_wdata_q <= bus.core_wdata;
      end else if (pop) begin
        rf_waddr_q <= head_data[36:32];
        rf_wdata_q <= head_data[31:0];
      end
    end
  end

  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.core_stall = (state == ST_FORCE);
  assign bus.fifo_count = fifo_cnt;
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb/tb_regfile_wport_arbiter.sv - self-checking bench for regfile_wport_arbiter
module tb_regfile_wport_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_wport_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

  regfile_wport_arbiter #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending IO writes, an integer starvation
  // count and a flag for the forced IO slot.
  wr_t         mq[$];
  int          m_starve;
  bit          m_force;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_rf [32];

  always @(posedge clk or negedge reset) begin
    int  sz;
    bit  core_ok;
    bit  popped;
    wr_t h;
    if (!reset) begin
      mq.delete();
      m_starve = 0;
      m_force  = 0;
      m_we     = 0;
      m_addr   = 0;
      m_data   = 0;
    end else begin
      sz      = mq.size();
      core_ok = bus.core_we && (bus.core_waddr != 0) && !m_force;
      popped  = 0;
      if (core_ok) begin
        m_we = 1; m_addr = bus.core_waddr; m_data = bus.core_wdata;
      end else if (sz > 0) begin
        h = mq.pop_front();
        m_we = 1; m_addr = h.a; m_data = h.d;
        popped = 1;
      end else begin
        m_we = 0;
      end
      if (m_we) m_rf[m_addr] = m_data;
      if (sz == 0 || popped) begin
        m_starve = 0;
        m_force  = 0;
      end else if (m_starve + 1 == LIMIT) begin
        m_starve = 0;
        m_force  = 1;
      end else begin
        m_starve++;
      end
      if (bus.io_valid && sz < DEPTH && bus.io_addr != 0) begin
        h.a = bus.io_addr; h.d = bus.io_data;
        mq.push_back(h);
      end
    end
  end

  // Compare process plus a log of what the DUT actually committed.
  wr_t         dut_log[$];
  logic [31:0] d_rf [32];

  always @(negedge clk) begin
    wr_t e;
    if (cmp_en) begin
      check("rf_we", 32'(bus.rf_we), 32'(m_we));
      check("rf_waddr", 32'(bus.rf_waddr), 32'(m_addr));
      check("rf_wdata", bus.rf_wdata, m_data);
      check("core_stall", 32'(bus.core_stall), 32'(m_force));
      check("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
      check("io_ready", 32'(bus.io_ready), 32'(mq.size() < DEPTH));
      if (bus.rf_we) begin
        e.a = bus.rf_waddr; e.d = bus.rf_wdata;
        dut_log.push_back(e);
        d_rf[bus.rf_waddr] = bus.rf_wdata;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic cwe, input logic [4:0] ca, input logic [31:0] cd,
                       input logic iv, input logic [4:0] ia, input logic [31:0] id);
    bus.core_we = cwe; bus.core_waddr = ca; bus.core_wdata = cd;
    bus.io_valid = iv; bus.io_addr = ia; bus.io_data = id;
  endtask

  // Core writeback source: advances to a new write only when the previous
  // cycle was not a stall, otherwise re-presents the same write.
  logic [31:0] cval;
  bit          prev_stall;

  task automatic core_step(input logic [4:0] a);
    if (!prev_stall) cval = cval + 1;
    prev_stall = bus.core_stall;
    bus.core_we = 1'b1; bus.core_waddr = a; bus.core_wdata = cval;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int stall_n;
    int stall_at;
    for (int i = 0; i < 32; i++) begin m_rf[i] = 0; d_rf[i] = 0; end
    drive(0, 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    #2;
    check("reset_rf_we", 32'(bus.rf_we), 32'd0);
    check("reset_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    check("reset_rf_wdata", bus.rf_wdata, 32'd0);
    check("reset_core_stall", 32'(bus.core_stall), 32'd0);
    check("reset_fifo_count", 32'(bus.fifo_count), 32'd0);
    check("reset_io_ready", 32'(bus.io_ready), 32'd1);
    tick(); tick();
    reset = 1'b1;
    cmp_en = 1;
    tick();

    // Core latency and x0 suppression.
    drive(1, 5'd5, 32'h1234, 0, 0, 0); tick();
    check("core_lat_we", 32'(bus.rf_we), 32'd1);
    check("core_lat_addr", 32'(bus.rf_waddr), 32'd5);
    check("core_lat_data", bus.rf_wdata, 32'h1234);
    drive(1, 5'd0, 32'h9999, 0, 0, 0); tick();
    check("core_x0_we", 32'(bus.rf_we), 32'd0);
    check("core_x0_hold_addr", 32'(bus.rf_waddr), 32'd5);
    drive(0, 0, 0, 0, 0, 0); tick();

    // IO drain with the core idle: two edges from push to rf_we.
    drive(0, 0, 0, 1, 5'd22, 32'd1); tick();
    check("io_push_we", 32'(bus.rf_we), 32'd0);
    check("io_push_count", 32'(bus.fifo_count), 32'd1);
    drive(0, 0, 0, 0, 0, 0); tick();
    check("io_drain_we", 32'(bus.rf_we), 32'd1);
    check("io_drain_addr", 32'(bus.rf_waddr), 32'd22);
    check("io_drain_data", bus.rf_wdata, 32'd1);
    check("io_drain_count", 32'(bus.fifo_count), 32'd0);
    drive(0, 0, 0, 1, 5'd0, 32'h77); tick();
    check("io_x0_count", 32'(bus.fifo_count), 32'd0);
    check("io_x0_we", 32'(bus.rf_we), 32'd0);
    drive(0, 0, 0, 0, 0, 0); tick();

    // Full FIFO behind continuous core writes.
    cval = 32'h2FF; prev_stall = 0;
    for (int i = 0; i < 4; i++) begin
      core_step(5'd3);
      bus.io_valid = 1'b1; bus.io_addr = 5'(8 + i); bus.io_data = 32'h80 + i;
      tick();
    end
    check("full_count", 32'(bus.fifo_count), 32'd4);
    check("full_io_ready", 32'(bus.io_ready), 32'd0);
    bus.io_addr = 5'd12; bus.io_data = 32'h55;
    for (int i = 0; i < 5; i++) begin core_step(5'd3); tick(); end
    check("full_force_stall", 32'(bus.core_stall), 32'd1);
    check("full_force_count", 32'(bus.fifo_count), 32'd4);
    core_step(5'd3); tick();
    check("full_pop_addr", 32'(bus.rf_waddr), 32'd8);
    check("full_pop_data", bus.rf_wdata, 32'h80);
    check("full_pop_count", 32'(bus.fifo_count), 32'd3);
    check("full_pop_ready", 32'(bus.io_ready), 32'd1);
    core_step(5'd3); tick();
    check("full_fifth_accepted", 32'(bus.fifo_count), 32'd4);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    check("full_drained", 32'(bus.fifo_count), 32'd0);
    check("full_last_addr", 32'(bus.rf_waddr), 32'd12);

    // Starvation: one queued IO entry behind back-to-back core writes.
    dut_log.delete();
    drive(1, 5'd0, 32'hDEAD, 1, 5'd4, 32'h44); tick();
    check("starve_setup_count", 32'(bus.fifo_count), 32'd1);
    bus.io_valid = 1'b0;
    cval = 32'hFF; prev_stall = 0; stall_n = 0; stall_at = -1;
    for (int i = 0; i < 10; i++) begin
      core_step(5'd10); tick();
      if (bus.core_stall) begin stall_n++; stall_at = i; end
    end
    drive(0, 0, 0, 0, 0, 0); tick();
    check("starve_stall_cycles", 32'(stall_n), 32'd1);
    check("starve_stall_after_8", 32'(stall_at), 32'd7);
    check("starve_log_size", 32'(dut_log.size()), 32'd10);
    if (dut_log.size() == 10) begin
      for (int i = 0; i < 8; i++)
        check("starve_core_commit", 32'(dut_log[i]), 32'({5'd10, 32'h100 + 32'(i)}));
      check("starve_io_commit", 32'(dut_log[8]), 32'({5'd4, 32'h44}));
      check("starve_held_commit", 32'(dut_log[9]), 32'({5'd10, 32'h108}));
    end

    // Ordering: C from core, then A and B from IO, all to x7.
    dut_log.delete();
    drive(1, 5'd7, 32'hC, 1, 5'd7, 32'hA); tick();
    drive(0, 0, 0, 1, 5'd7, 32'hB); tick();
    drive(0, 0, 0, 0, 0, 0); tick(); tick();
    check("order_log_size", 32'(dut_log.size()), 32'd3);
    if (dut_log.size() == 3) begin
      check("order_first", dut_log[0].d, 32'hC);
      check("order_second", dut_log[1].d, 32'hA);
      check("order_third", dut_log[2].d, 32'hB);
    end
    check("order_dut_x7", d_rf[7], 32'hB);
    check("order_model_x7", m_rf[7], 32'hB);

    // Asynchronous reset mid-stream with three IO entries queued.
    cval = 32'h1FF; prev_stall = 0;
    for (int i = 0; i < 3; i++) begin
      core_step(5'd2);
      bus.io_valid = 1'b1; bus.io_addr = 5'(20 + i); bus.io_data = 32'h200 + i;
      tick();
    end
    check("rst_pre_count", 32'(bus.fifo_count), 32'd3);
    check("rst_pre_we", 32'(bus.rf_we), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_async_we", 32'(bus.rf_we), 32'd0);
    check("rst_async_waddr", 32'(bus.rf_waddr), 32'd0);
    check("rst_async_wdata", bus.rf_wdata, 32'd0);
    check("rst_async_stall", 32'(bus.core_stall), 32'd0);
    check("rst_async_count", 32'(bus.fifo_count), 32'd0);
    check("rst_async_ready", 32'(bus.io_ready), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_pulse", 32'(bus.rf_we), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
